// File: rtl/rv32i_pkg.sv
// rv32i_pkg: opcodes, control enums and the funct3-to-ALU decode shared by the RV32I core.
package rv32i_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
    } alu_op_t;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_t;

    typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_t;

    // alt selects SUB/SRA; the caller decides when instruction bit 30 is meaningful
    function automatic alu_op_t alu_from_funct3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_regfile.sv
// rv32i_regfile: 32-entry register file, x0 reads zero, two combinational reads, one clocked write.
// Ports: clk, rst (async, active-high, clears all entries), we/wa/wd write port,
//        ra1/rd1 and ra2/rd2 read ports (a same-cycle write is seen on the next cycle).
module rv32i_regfile #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [4:0]        ra1,
    input  logic [4:0]        ra2,
    input  logic [4:0]        wa,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2
);

    logic [DATA_W-1:0] regs [32];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (we && wa != 5'd0) begin
            regs[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == 5'd0) ? '0 : regs[ra1];
    assign rd2 = (ra2 == 5'd0) ? '0 : regs[ra2];

endmodule

// File: rtl/rv32i_single_cycle_core.sv
// rv32i_single_cycle_core: single-cycle RV32I core, one instruction retired per CLK.
// Ports: CLK; RESET_N (async, ACTIVE-HIGH despite its name);
//        iaddr/idata to a combinational instruction ROM;
//        daddr/ddata_w/ddata_r/MemRead/MemWrite to a data RAM (sync write, comb read).
// Build option: ILLEGAL_HALT_EN freezes the PC on an unrecognised opcode; otherwise it is a NOP.
module rv32i_single_cycle_core
    import rv32i_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [DATA_W-1:0] idata,
    input  logic [DATA_W-1:0] ddata_r,
    output logic [ADDR_W-1:0] iaddr,
    output logic [DATA_W-1:0] ddata_w,
    output logic [ADDR_W-1:0] daddr,
    output logic              MemRead,
    output logic              MemWrite
);

`ifdef ILLEGAL_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic [ADDR_W-1:0] pc, pc_next, pc_seq, pc_plus4, pc_imm, jalr_tgt, alu_addr;
    logic [6:0]        opcode;
    logic [4:0]        rd, rs1, rs2;
    logic [2:0]        f3;
    logic [DATA_W-1:0] rs1_v, rs2_v, imm, alu_a, alu_b, alu_y, wb_data;
    logic [DATA_W-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    alu_op_t           alu_op;
    imm_sel_t          imm_sel;
    wb_sel_t           wb_sel;
    logic              src_a_pc, src_b_imm, reg_we, mem_rd, mem_wr;
    logic              branch, jal, jalr, illegal, br_cond, eq, lt, ltu;

    assign opcode = idata[6:0];
    assign rd     = idata[11:7];
    assign f3     = idata[14:12];
    assign rs1    = idata[19:15];
    assign rs2    = idata[24:20];

    assign imm_i = DATA_W'($signed(idata[31:20]));
    assign imm_s = DATA_W'($signed({idata[31:25], idata[11:7]}));
    assign imm_b = DATA_W'($signed({idata[31], idata[7], idata[30:25], idata[11:8], 1'b0}));
    assign imm_u = DATA_W'($signed({idata[31:12], 12'b0}));
    assign imm_j = DATA_W'($signed({idata[31], idata[19:12], idata[20], idata[30:21], 1'b0}));

    assign imm = imm_sel == IMM_S ? imm_s :
                 imm_sel == IMM_B ? imm_b :
                 imm_sel == IMM_U ? imm_u :
                 imm_sel == IMM_J ? imm_j : imm_i;

    always_comb begin
        alu_op    = ALU_ADD;
        imm_sel   = IMM_I;
        wb_sel    = WB_ALU;
        src_a_pc  = 1'b0;
        src_b_imm = 1'b0;
        reg_we    = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        branch    = 1'b0;
        jal       = 1'b0;
        jalr      = 1'b0;
        illegal   = 1'b0;
        case (opcode)
            OP_R: begin
                reg_we = 1'b1;
                alu_op = alu_from_funct3(f3, idata[30]);
            end
            OP_I: begin
                reg_we    = 1'b1;
                src_b_imm = 1'b1;
                // bit 30 is part of the immediate except for SRAI
                alu_op    = alu_from_funct3(f3, f3 == 3'b101 && idata[30]);
            end
            OP_LOAD: begin
                reg_we    = 1'b1;
                src_b_imm = 1'b1;
                wb_sel    = WB_MEM;
                mem_rd    = 1'b1;
            end
            OP_STORE: begin
                imm_sel   = IMM_S;
                src_b_imm = 1'b1;
                mem_wr    = 1'b1;
            end
            OP_BRANCH: begin
                imm_sel = IMM_B;
                branch  = 1'b1;
            end
            OP_JAL: begin
                imm_sel = IMM_J;
                reg_we  = 1'b1;
                wb_sel  = WB_PC4;
                jal     = 1'b1;
            end
            OP_JALR: begin
                src_b_imm = 1'b1;
                reg_we    = 1'b1;
                wb_sel    = WB_PC4;
                jalr      = 1'b1;
            end
            OP_LUI: begin
                imm_sel   = IMM_U;
                src_b_imm = 1'b1;
                reg_we    = 1'b1;
                alu_op    = ALU_PASSB;
            end
            OP_AUIPC: begin
                imm_sel   = IMM_U;
                src_a_pc  = 1'b1;
                src_b_imm = 1'b1;
                reg_we    = 1'b1;
            end
            OP_FENCE, OP_SYSTEM: ;
            default: illegal = 1'b1;
        endcase
    end

    assign alu_a = src_a_pc ? DATA_W'(pc) : rs1_v;
    assign alu_b = src_b_imm ? imm : rs2_v;

    always_comb begin
        case (alu_op)
            ALU_ADD:   alu_y = alu_a + alu_b;
            ALU_SUB:   alu_y = alu_a - alu_b;
            ALU_SLL:   alu_y = alu_a << alu_b[4:0];
            ALU_SLT:   alu_y = DATA_W'($signed(alu_a) < $signed(alu_b));
            ALU_SLTU:  alu_y = DATA_W'(alu_a < alu_b);
            ALU_XOR:   alu_y = alu_a ^ alu_b;
            ALU_SRL:   alu_y = alu_a >> alu_b[4:0];
            ALU_SRA:   alu_y = $signed(alu_a) >>> alu_b[4:0];
            ALU_OR:    alu_y = alu_a | alu_b;
            ALU_AND:   alu_y = alu_a & alu_b;
            ALU_PASSB: alu_y = alu_b;
            default:   alu_y = alu_a + alu_b;
        endcase
    end

    assign eq  = rs1_v == rs2_v;
    assign lt  = $signed(rs1_v) < $signed(rs2_v);
    assign ltu = rs1_v < rs2_v;
    assign br_cond = f3 == 3'b000 ? eq  :
                     f3 == 3'b001 ? !eq :
                     f3 == 3'b100 ? lt  :
                     f3 == 3'b101 ? !lt :
                     f3 == 3'b110 ? ltu :
                     f3 == 3'b111 ? !ltu : 1'b0;

    assign alu_addr = ADDR_W'(alu_y);
    assign pc_plus4 = pc + ADDR_W'(4);
    assign pc_imm   = pc + ADDR_W'(imm);
    assign jalr_tgt = {alu_addr[ADDR_W-1:1], 1'b0};
    assign pc_seq   = jalr ? jalr_tgt : (jal || (branch && br_cond)) ? pc_imm : pc_plus4;
    assign pc_next  = (HALT_EN && illegal) ? pc : pc_seq;

    // rd is written at the clock edge, after jalr_tgt has used the old rs1, so rd==rs1 is safe
    assign wb_data = wb_sel == WB_MEM ? ddata_r :
                     wb_sel == WB_PC4 ? DATA_W'(pc_plus4) : alu_y;

    always_ff @(posedge CLK or posedge RESET_N) begin
        if (RESET_N) pc <= RESET_PC;
        else         pc <= pc_next;
    end

    rv32i_regfile #(.DATA_W(DATA_W)) u_regfile (
        .clk (CLK),
        .rst (RESET_N),
        .we  (reg_we),
        .ra1 (rs1),
        .ra2 (rs2),
        .wa  (rd),
        .wd  (wb_data),
        .rd1 (rs1_v),
        .rd2 (rs2_v)
    );

    assign iaddr    = pc;
    assign daddr    = alu_addr;
    assign ddata_w  = rs2_v;
    assign MemRead  = mem_rd && !RESET_N;
    assign MemWrite = mem_wr && !RESET_N;

endmodule

// File: tb/tb_rv32i_single_cycle_core.sv
// tb_rv32i_single_cycle_core: lockstep check of the core against an instruction-level reference model.
module tb_rv32i_single_cycle_core;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic [31:0] idata, ddata_r, iaddr, ddata_w, daddr;
    logic        MemRead, MemWrite;

    logic [31:0] rom [1024];
    logic [31:0] ram [1024];

    logic [31:0] m_x [32];
    logic [31:0] m_mem [1024];
    logic [31:0] m_pc, prev_pc;
    bit          directed;
    int          cyc;
    int          checks = 0;
    int          errors = 0;

    rv32i_single_cycle_core dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .idata    (idata),
        .ddata_r  (ddata_r),
        .iaddr    (iaddr),
        .ddata_w  (ddata_w),
        .daddr    (daddr),
        .MemRead  (MemRead),
        .MemWrite (MemWrite)
    );

    always #5 CLK = ~CLK;

    assign idata   = rom[iaddr[11:2]];
    assign ddata_r = ram[daddr[11:2]];
    always @(posedge CLK) if (MemWrite) ram[daddr[11:2]] <= ddata_w;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rd, op};
    endfunction

    function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic alt,
                                            input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        sh = b % 32;
        case (f3)
            3'd0: return alt ? a - b : a + b;
            3'd1: return a << sh;
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return alt ? 32'($signed(a) >>> sh) : a >> sh;
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    // Executes the instruction at m_pc on the model and reports the memory-port activity it implies.
    task automatic model_step(output logic er, output logic ew, output logic [31:0] ea, output logic [31:0] ewd);
        logic [31:0] ins, a, b, iimm, simm, bimm, jimm, wv, nxt;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        we, tk;
        ins  = rom[m_pc[11:2]];
        op   = ins[6:0];
        rd   = ins[11:7];
        f3   = ins[14:12];
        a    = m_x[ins[19:15]];
        b    = m_x[ins[24:20]];
        iimm = 32'($signed(ins[31:20]));
        simm = 32'($signed({ins[31:25], ins[11:7]}));
        bimm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
        jimm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
        er = 1'b0; ew = 1'b0; ea = 32'h0; ewd = 32'h0;
        we = 1'b0; wv = 32'h0; tk = 1'b0;
        nxt = m_pc + 32'd4;
        case (op)
            7'h37: begin we = 1'b1; wv = {ins[31:12], 12'h000}; end
            7'h17: begin we = 1'b1; wv = m_pc + {ins[31:12], 12'h000}; end
            7'h6f: begin we = 1'b1; wv = m_pc + 32'd4; nxt = m_pc + jimm; end
            7'h67: begin we = 1'b1; wv = m_pc + 32'd4; nxt = (a + iimm) & ~32'd1; end
            7'h63: begin
                case (f3)
                    3'd0: tk = a == b;
                    3'd1: tk = a != b;
                    3'd4: tk = $signed(a) < $signed(b);
                    3'd5: tk = $signed(a) >= $signed(b);
                    3'd6: tk = a < b;
                    3'd7: tk = a >= b;
                    default: tk = 1'b0;
                endcase
                if (tk) nxt = m_pc + bimm;
            end
            7'h03: begin er = 1'b1; ea = a + iimm; we = 1'b1; wv = m_mem[ea[11:2]]; end
            7'h23: begin ew = 1'b1; ea = a + simm; ewd = b; m_mem[ea[11:2]] = b; end
            7'h13: begin we = 1'b1; wv = ref_alu(f3, f3 == 3'd5 && ins[30], a, iimm); end
            7'h33: begin we = 1'b1; wv = ref_alu(f3, ins[30], a, b); end
            7'h0f, 7'h73: ;
            default: begin
`ifdef ILLEGAL_HALT_EN
                nxt = m_pc;
`endif
            end
        endcase
        if (we && rd != 5'd0) m_x[rd] = wv;
        m_pc = nxt;
    endtask

    task automatic run_cycle();
        logic        er, ew;
        logic [31:0] ea, ewd, epc;
        epc = m_pc;
        model_step(er, ew, ea, ewd);
        check("iaddr", iaddr, epc);
        check("MemRead", {31'b0, MemRead}, {31'b0, er});
        check("MemWrite", {31'b0, MemWrite}, {31'b0, ew});
        if (er || ew) check("daddr", daddr, ea);
        if (ew) check("ddata_w", ddata_w, ewd);
        if (directed) begin
            if (cyc < 3) check("reset_step", iaddr, 32'(cyc * 4));
            case (prev_pc)
                32'h20: check("beq_taken", iaddr, 32'h28);
                32'h28: check("bne_not_taken", iaddr, 32'h2C);
                32'h40: check("jal_target", iaddr, 32'h50);
                32'h50: check("jalr_target", iaddr, 32'h44);
                default: ;
            endcase
            case (epc)
                32'h18: check("sw_daddr", daddr, 32'h8);
                32'h1C: check("lw_memread", {31'b0, MemRead}, 32'h1);
                32'h54: check("x1_link", ddata_w, 32'h44);
                32'h58: check("x2_addi_neg", ddata_w, 32'hFFFFFFFD);
                32'h5C: check("x3_add", ddata_w, 32'h2);
                32'h60: check("x4_sub", ddata_w, 32'hFFFFFFF8);
                32'h64: check("x5_slt", ddata_w, 32'h1);
                32'h68: check("x6_lw", ddata_w, 32'h2);
                32'h6C: check("x7_x0_zero", ddata_w, 32'h0);
                32'h70: check("x8_lui", ddata_w, 32'h12345000);
                32'h74: check("x9_srai", ddata_w, 32'hFFFFFFFE);
                32'h78: check("x10_sltu", ddata_w, 32'h0);
                32'h7C: check("x11_skipped", ddata_w, 32'h0);
                default: ;
            endcase
        end
        prev_pc = epc;
        cyc++;
        @(negedge CLK);
    endtask

    function automatic logic [31:0] rand_ins(input int p);
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [11:0] imm;
        int          k;
        rd  = 5'($urandom_range(0, 31));
        rs1 = 5'($urandom_range(0, 31));
        rs2 = 5'($urandom_range(0, 31));
        f3  = 3'($urandom_range(0, 7));
        imm = 12'($urandom);
        k   = $urandom_range(0, 10);
        case (k)
            0: return enc_u(20'($urandom), rd, 7'h37);
            1: return enc_u(20'($urandom), rd, 7'h17);
            2, 3: begin
                if (f3 == 3'd1) imm = {7'b0, imm[4:0]};
                if (f3 == 3'd5) imm = {($urandom_range(0, 1) == 1) ? 7'b0100000 : 7'b0, imm[4:0]};
                return enc_i(imm, rs1, f3, rd, 7'h13);
            end
            4, 5: return enc_r((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1 ? 7'h20 : 7'h00,
                               rs2, rs1, f3, rd);
            6: begin
                if (f3 == 3'd2 || f3 == 3'd3) f3 = 3'd0;
                return enc_b(13'(4 * $urandom_range(1, 4)), rs2, rs1, f3);
            end
            7: return enc_j(21'(4 * $urandom_range(1, 4)), rd);
            8: return enc_i(12'(p + 4 * $urandom_range(1, 4) + $urandom_range(0, 1)), 5'd0, 3'd0, rd, 7'h67);
            9: return ($urandom_range(0, 1) == 1) ? enc_i(imm, rs1, 3'b010, rd, 7'h03) : enc_s(imm, rs2, rs1);
            default: begin
`ifndef ILLEGAL_HALT_EN
                if ($urandom_range(0, 2) == 0) return 32'h0000007F;
`endif
                return ($urandom_range(0, 1) == 1) ? 32'h0000000F : 32'h00000073;
            end
        endcase
    endfunction

    initial begin
        int          idx;
        logic [31:0] end_pc;
        for (int i = 0; i < 1024; i++) begin
            rom[i]   = 32'h0;
            ram[i]   = $urandom;
            m_mem[i] = ram[i];
        end
        for (int i = 0; i < 32; i++) m_x[i] = 32'h0;
        rom[0]  = enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'h13);
        rom[1]  = enc_i(12'hFFD, 5'd0, 3'd0, 5'd2, 7'h13);
        rom[2]  = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3);
        rom[3]  = enc_r(7'h20, 5'd1, 5'd2, 3'd0, 5'd4);
        rom[4]  = enc_r(7'h00, 5'd1, 5'd2, 3'd2, 5'd5);
        rom[5]  = enc_r(7'h00, 5'd1, 5'd2, 3'd3, 5'd10);
        rom[6]  = enc_s(12'd8, 5'd3, 5'd0);
        rom[7]  = enc_i(12'd8, 5'd0, 3'b010, 5'd6, 7'h03);
        rom[8]  = enc_b(13'd8, 5'd0, 5'd0, 3'd0);
        rom[9]  = enc_i(12'd1, 5'd0, 3'd0, 5'd11, 7'h13);
        rom[10] = enc_b(13'd8, 5'd0, 5'd0, 3'd1);
        rom[11] = enc_i(12'd7, 5'd0, 3'd0, 5'd0, 7'h13);
        rom[12] = enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd7);
        rom[13] = enc_u(20'h12345, 5'd8, 7'h37);
        rom[14] = enc_i(12'h401, 5'd2, 3'd5, 5'd9, 7'h13);
        rom[15] = enc_i(12'd0, 5'd0, 3'd0, 5'd0, 7'h13);
        rom[16] = enc_j(21'd16, 5'd1);
        rom[17] = enc_j(21'd16, 5'd0);
        rom[18] = enc_i(12'd0, 5'd0, 3'd0, 5'd0, 7'h13);
        rom[19] = enc_i(12'd0, 5'd0, 3'd0, 5'd0, 7'h13);
        rom[20] = enc_i(12'd0, 5'd1, 3'd0, 5'd0, 7'h67);
        for (int i = 1; i < 32; i++) rom[20 + i] = enc_s(12'(256 + 4 * i), 5'(i), 5'd0);
        idx = 52;
        for (int i = 0; i < 160; i++) begin
            rom[idx] = rand_ins(idx * 4);
            idx++;
        end
        for (int i = 0; i < 4; i++) begin
            rom[idx] = enc_i(12'd0, 5'd0, 3'd0, 5'd0, 7'h13);
            idx++;
        end
        for (int i = 1; i < 32; i++) begin
            rom[idx] = enc_s(12'(512 + 4 * i), 5'(i), 5'd0);
            idx++;
        end
        end_pc = 32'(idx * 4);

        m_pc = 32'h0; prev_pc = 32'hFFFFFFFF; cyc = 0; directed = 1'b1;
        #1 RESET_N = 1'b1;
        @(negedge CLK);
        check("rst_iaddr_0", iaddr, 32'h0);
        @(negedge CLK);
        check("rst_iaddr_1", iaddr, 32'h0);
        check("rst_memread", {31'b0, MemRead}, 32'h0);
        check("rst_memwrite", {31'b0, MemWrite}, 32'h0);
        RESET_N = 1'b0;
        #1;
        for (int n = 0; n < 100 && m_pc != 32'hD0; n++) run_cycle();
        check("directed_end", iaddr, 32'hD0);
        directed = 1'b0;
        for (int n = 0; n < 2000 && m_pc != end_pc; n++) run_cycle();
        check("random_end", iaddr, end_pc);

        rom[0] = enc_s(12'd0, 5'd3, 5'd0);
        RESET_N = 1'b1;
        #1;
        check("async_rst_iaddr", iaddr, 32'h0);
        check("rst_force_memwrite", {31'b0, MemWrite}, 32'h0);
        @(negedge CLK);
        @(negedge CLK);
        RESET_N = 1'b0;
        #1;
        check("post_rst_memwrite", {31'b0, MemWrite}, 32'h1);
        check("post_rst_daddr", daddr, 32'h0);
        check("post_rst_x3_cleared", ddata_w, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
